ctrl_cmd_initiator: RTL and testbench

//  Initiator side of the UDP control-command protocol (port 0x6789, trailing magic word 0xCBAE).

---
 rtl/ctrl_pkg.sv | 15 +
 rtl/generic_spram.sv | 32 +++
 rtl/ctrl_cmd_initiator.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_ctrl_cmd_initiator.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Constants and FSM encoding shared by the UDP control-command initiator and its peers.
package ctrl_pkg;

    localparam logic [15:0] CTRL_UDP_PORT = 16'h6789;
    localparam logic [15:0] MAGIC_WORD    = 16'hCBAE;

    typedef enum logic [2:0] {
        StIdle,
        StTxHdr,
        StTxPay,
        StWaitRsp,
        StRxPay
    } ctrl_state_e;

endpackage

// File: rtl/generic_spram.sv
// Single-port RAM; LATENCY 0 gives an asynchronous read, anything else a registered read.
module generic_spram #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned AW      = 10,
    parameter int unsigned DW      = 16
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    if (LATENCY == 0) begin : g_comb_rd
        assign rdata_o = mem[addr_i];
    end else begin : g_reg_rd
        logic [DW-1:0] rdata_q;
        always_ff @(posedge clk) begin
            rdata_q <= mem[addr_i];
        end
        assign rdata_o = rdata_q;
    end

endmodule

// File: rtl/ctrl_cmd_initiator.sv
// Frames buffered 16-bit command words into one UDP command packet, then collects the
// matching UDP response into a response buffer and reports done or err.
module ctrl_cmd_initiator
    import ctrl_pkg::*;
#(
    parameter int unsigned AW          = 10,
    parameter logic [15:0] LOCAL_PORT  = 16'h6788,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_wr,
    input  logic [15:0]   cmd_data,
    input  logic          go,
    input  logic [31:0]   dst_ip,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] rsp_len,
    input  logic [AW-1:0] rsp_addr,
    output logic [15:0]   rsp_q,
    output logic          tx_udp_hdr_valid,
    input  logic          tx_udp_hdr_ready,
    output logic [31:0]   tx_ip_dest_ip,
    output logic [15:0]   tx_udp_source_port,
    output logic [15:0]   tx_udp_dest_port,
    output logic [15:0]   tx_udp_length,
    output logic [7:0]    tx_payload_tdata,
    output logic          tx_payload_tvalid,
    input  logic          tx_payload_tready,
    output logic          tx_payload_tlast,
    input  logic          rx_udp_hdr_valid,
    output logic          rx_udp_hdr_ready,
    input  logic [31:0]   rx_ip_source_ip,
    input  logic [15:0]   rx_udp_source_port,
    input  logic [15:0]   rx_udp_dest_port,
    input  logic [15:0]   rx_udp_length,
    input  logic [7:0]    rx_payload_tdata,
    input  logic          rx_payload_tvalid,
    output logic          rx_payload_tready,
    input  logic          rx_payload_tlast,
    input  logic          rx_udp_err
);

    localparam logic [AW-1:0] CMD_MAX = AW'(2**AW - 2);
    localparam logic [AW-1:0] RSP_MAX = '1;
    localparam logic [AW-1:0] ONE_AW  = AW'(1);

    ctrl_state_e   state_q, state_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d, ovf_q, ovf_d;
    logic [AW-1:0] cmd_cnt_q, cmd_cnt_d, word_idx_q, word_idx_d, rsp_len_q, rsp_len_d;
    logic [31:0]   dst_ip_q, dst_ip_d, timer_q, timer_d;
    logic [15:0]   tx_len_q, tx_len_d, cur_word_q, cur_word_d;
    logic          hdr_valid_q, hdr_valid_d, tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [7:0]    tdata_q, tdata_d, rx_hi_q, rx_hi_d;
    logic          tx_lo_q, tx_lo_d, rx_lo_q, rx_lo_d, drain_q, drain_d;

    logic          cmd_we, rsp_we, rx_hdr_fire, rsp_match, timeout;
    logic [AW-1:0] last_idx, next_idx, cmd_addr, rsp_ram_addr;
    logic [15:0]   cmd_rdata, cnt_word, next_word;
    logic [31:0]   timer_inc;
    logic          unused_rx_len;

    assign unused_rx_len = ^rx_udp_length;

    assign rx_udp_hdr_ready  = !rst && !drain_q && (state_q == StIdle || state_q == StWaitRsp);
    assign rx_payload_tready = drain_q || (state_q == StRxPay);

    assign rx_hdr_fire = rx_udp_hdr_valid && rx_udp_hdr_ready;
    assign rsp_match   = (rx_ip_source_ip == dst_ip_q) && (rx_udp_source_port == CTRL_UDP_PORT)
                      && (rx_udp_dest_port == LOCAL_PORT) && !rx_udp_err;
    assign timer_inc   = timer_q + 32'd1;
    assign timeout     = (timer_inc == TIMEOUT_CYC);
    assign last_idx    = cmd_cnt_q + ONE_AW;
    assign next_idx    = word_idx_q + ONE_AW;
    assign cnt_word    = 16'(cmd_cnt_q) + 16'd1;
    // RAM sits at the current word index while it is sent, so the next word is already read.
    assign next_word   = (next_idx == last_idx) ? MAGIC_WORD : cmd_rdata;
    assign cmd_addr    = (state_q == StIdle) ? cmd_cnt_q : word_idx_q;
    assign rsp_ram_addr = rsp_we ? rsp_len_q : rsp_addr;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ovf_d       = ovf_q;
        cmd_cnt_d   = cmd_cnt_q;
        word_idx_d  = word_idx_q;
        rsp_len_d   = rsp_len_q;
        dst_ip_d    = dst_ip_q;
        timer_d     = timer_q;
        tx_len_d    = tx_len_q;
        cur_word_d  = cur_word_q;
        hdr_valid_d = hdr_valid_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        rx_hi_d     = rx_hi_q;
        tx_lo_d     = tx_lo_q;
        rx_lo_d     = rx_lo_q;
        drain_d     = drain_q;
        cmd_we      = 1'b0;
        rsp_we      = 1'b0;

        if (drain_q && rx_payload_tvalid && rx_payload_tlast) begin
            drain_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (rx_hdr_fire) begin
                    drain_d = 1'b1;
                end
                if (go) begin
                    rsp_len_d = '0;
                    if (cmd_cnt_q == '0 || ovf_q) begin
                        err_d     = 1'b1;
                        cmd_cnt_d = '0;
                        ovf_d     = 1'b0;
                    end else begin
                        busy_d      = 1'b1;
                        dst_ip_d    = dst_ip;
                        tx_len_d    = 16'd12 + (16'(cmd_cnt_q) << 1);
                        hdr_valid_d = 1'b1;
                        word_idx_d  = '0;
                        state_d     = StTxHdr;
                    end
                end else if (cmd_wr) begin
                    if (cmd_cnt_q == CMD_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cmd_we    = 1'b1;
                        cmd_cnt_d = cmd_cnt_q + ONE_AW;
                    end
                end
            end
            StTxHdr: begin
                if (tx_udp_hdr_ready) begin
                    hdr_valid_d = 1'b0;
                    tvalid_d    = 1'b1;
                    cur_word_d  = cnt_word;
                    tdata_d     = cnt_word[15:8];
                    tx_lo_d     = 1'b0;
                    tlast_d     = 1'b0;
                    state_d     = StTxPay;
                end
            end
            StTxPay: begin
                if (tx_payload_tready) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        timer_d  = '0;
                        state_d  = StWaitRsp;
                    end else if (!tx_lo_q) begin
                        tdata_d = cur_word_q[7:0];
                        tx_lo_d = 1'b1;
                        tlast_d = (word_idx_q == last_idx);
                    end else begin
                        cur_word_d = next_word;
                        tdata_d    = next_word[15:8];
                        word_idx_d = next_idx;
                        tx_lo_d    = 1'b0;
                    end
                end
            end
            StWaitRsp: begin
                timer_d = timer_inc;
                if (timeout) begin
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    cmd_cnt_d = '0;
                    ovf_d     = 1'b0;
                    state_d   = StIdle;
                    if (rx_hdr_fire) begin
                        drain_d = 1'b1;
                    end
                end else if (rx_hdr_fire) begin
                    if (rsp_match) begin
                        rx_lo_d = 1'b0;
                        state_d = StRxPay;
                    end else begin
                        drain_d = 1'b1;
                    end
                end
            end
            StRxPay: begin
                timer_d = timer_inc;
                if (rx_payload_tvalid) begin
                    if (!rx_lo_q) begin
                        rx_hi_d = rx_payload_tdata;
                        rx_lo_d = 1'b1;
                    end else begin
                        rx_lo_d = 1'b0;
                        if (rsp_len_q != RSP_MAX) begin
                            rsp_we    = 1'b1;
                            rsp_len_d = rsp_len_q + ONE_AW;
                        end
                    end
                end
                if (rx_payload_tvalid && rx_payload_tlast) begin
                    // A frame ending on a high byte has an odd byte count.
                    err_d     = !rx_lo_q;
                    done_d    = rx_lo_q;
                    busy_d    = 1'b0;
                    cmd_cnt_d = '0;
                    ovf_d     = 1'b0;
                    state_d   = StIdle;
                end else if (timeout) begin
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    cmd_cnt_d = '0;
                    ovf_d     = 1'b0;
                    drain_d   = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cmd_cnt_q   <= '0;
            word_idx_q  <= '0;
            rsp_len_q   <= '0;
            dst_ip_q    <= '0;
            timer_q     <= '0;
            tx_len_q    <= '0;
            cur_word_q  <= '0;
            hdr_valid_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            rx_hi_q     <= '0;
            tx_lo_q     <= 1'b0;
            rx_lo_q     <= 1'b0;
            drain_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            cmd_cnt_q   <= cmd_cnt_d;
            word_idx_q  <= word_idx_d;
            rsp_len_q   <= rsp_len_d;
            dst_ip_q    <= dst_ip_d;
            timer_q     <= timer_d;
            tx_len_q    <= tx_len_d;
            cur_word_q  <= cur_word_d;
            hdr_valid_q <= hdr_valid_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            rx_hi_q     <= rx_hi_d;
            tx_lo_q     <= tx_lo_d;
            rx_lo_q     <= rx_lo_d;
            drain_q     <= drain_d;
        end
    end

    generic_spram #(
        .LATENCY(1),
        .AW     (AW),
        .DW     (16)
    ) u_cmd_ram (
        .clk    (clk),
        .we_i   (cmd_we),
        .addr_i (cmd_addr),
        .wdata_i(cmd_data),
        .rdata_o(cmd_rdata)
    );

    generic_spram #(
        .LATENCY(1),
        .AW     (AW),
        .DW     (16)
    ) u_rsp_ram (
        .clk    (clk),
        .we_i   (rsp_we),
        .addr_i (rsp_ram_addr),
        .wdata_i({rx_hi_q, rx_payload_tdata}),
        .rdata_o(rsp_q)
    );

    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;
    assign rsp_len            = rsp_len_q;
    assign tx_udp_hdr_valid   = hdr_valid_q;
    assign tx_ip_dest_ip      = dst_ip_q;
    assign tx_udp_source_port = LOCAL_PORT;
    assign tx_udp_dest_port   = CTRL_UDP_PORT;
    assign tx_udp_length      = tx_len_q;
    assign tx_payload_tdata   = tdata_q;
    assign tx_payload_tvalid  = tvalid_q;
    assign tx_payload_tlast   = tlast_q;

endmodule

// File: tb/tb_ctrl_cmd_initiator.sv
// Directed bench for ctrl_cmd_initiator: framing, stalls, response capture, foreign frames,
// timeout, empty/overflowed buffer and reset mid-frame.
module tb_ctrl_cmd_initiator;

    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst, cmd_wr, go;
    logic [15:0]   cmd_data;
    logic [31:0]   dst_ip;
    logic          busy, done, err;
    logic [AW-1:0] rsp_len, rsp_addr;
    logic [15:0]   rsp_q;
    logic          tx_udp_hdr_valid, tx_udp_hdr_ready;
    logic [31:0]   tx_ip_dest_ip;
    logic [15:0]   tx_udp_source_port, tx_udp_dest_port, tx_udp_length;
    logic [7:0]    tx_payload_tdata;
    logic          tx_payload_tvalid, tx_payload_tready, tx_payload_tlast;
    logic          rx_udp_hdr_valid, rx_udp_hdr_ready;
    logic [31:0]   rx_ip_source_ip;
    logic [15:0]   rx_udp_source_port, rx_udp_dest_port, rx_udp_length;
    logic [7:0]    rx_payload_tdata;
    logic          rx_payload_tvalid, rx_payload_tready, rx_payload_tlast;
    logic          rx_udp_err;

    int total = 0;
    int bad   = 0;
    int n;
    int cnt;
    logic [7:0] txb [16];
    logic [7:0] rxb [4];
    logic [7:0] exp_a [8]  = '{8'h00, 8'h03, 8'h00, 8'h01, 8'h12, 8'h34, 8'hCB, 8'hAE};
    logic [7:0] exp_b [10] = '{8'h00, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6,
                               8'hCB, 8'hAE};

    always #5 clk = ~clk;

    ctrl_cmd_initiator #(
        .AW         (AW),
        .LOCAL_PORT (16'h6788),
        .TIMEOUT_CYC(32'd100)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_wr            (cmd_wr),
        .cmd_data          (cmd_data),
        .go                (go),
        .dst_ip            (dst_ip),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .rsp_len           (rsp_len),
        .rsp_addr          (rsp_addr),
        .rsp_q             (rsp_q),
        .tx_udp_hdr_valid  (tx_udp_hdr_valid),
        .tx_udp_hdr_ready  (tx_udp_hdr_ready),
        .tx_ip_dest_ip     (tx_ip_dest_ip),
        .tx_udp_source_port(tx_udp_source_port),
        .tx_udp_dest_port  (tx_udp_dest_port),
        .tx_udp_length     (tx_udp_length),
        .tx_payload_tdata  (tx_payload_tdata),
        .tx_payload_tvalid (tx_payload_tvalid),
        .tx_payload_tready (tx_payload_tready),
        .tx_payload_tlast  (tx_payload_tlast),
        .rx_udp_hdr_valid  (rx_udp_hdr_valid),
        .rx_udp_hdr_ready  (rx_udp_hdr_ready),
        .rx_ip_source_ip   (rx_ip_source_ip),
        .rx_udp_source_port(rx_udp_source_port),
        .rx_udp_dest_port  (rx_udp_dest_port),
        .rx_udp_length     (rx_udp_length),
        .rx_payload_tdata  (rx_payload_tdata),
        .rx_payload_tvalid (rx_payload_tvalid),
        .rx_payload_tready (rx_payload_tready),
        .rx_payload_tlast  (rx_payload_tlast),
        .rx_udp_err        (rx_udp_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        cmd_wr = 1'b1;
        cmd_data = d;
        step();
        cmd_wr = 1'b0;
    endtask

    task automatic start(input logic [31:0] ip);
        dst_ip = ip;
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    task automatic tx_hdr(input logic [31:0] ip, input logic [15:0] len);
        int c = 0;
        while (!tx_udp_hdr_valid && c < 20) begin
            step();
            c++;
        end
        step();
        chk("tx_hdr_valid_held", tx_udp_hdr_valid, 1);
        chk("tx_len", tx_udp_length, len);
        chk("tx_ip", tx_ip_dest_ip, ip);
        chk("tx_dport", tx_udp_dest_port, 16'h6789);
        chk("tx_sport", tx_udp_source_port, 16'h6788);
        tx_udp_hdr_ready = 1'b1;
        step();
        tx_udp_hdr_ready = 1'b0;
        chk("tx_hdr_dropped", tx_udp_hdr_valid, 0);
    endtask

    task automatic tx_collect(input bit stall, output int nb);
        logic [7:0] prev = '0;
        bit held = 1'b0;
        bit got_last = 1'b0;
        nb = 0;
        for (int c = 0; c < 300 && !got_last; c++) begin
            tx_payload_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held) begin
                chk("tx_stall_valid", tx_payload_tvalid, 1);
                chk("tx_stall_data", tx_payload_tdata, prev);
            end
            held = tx_payload_tvalid && !tx_payload_tready;
            prev = tx_payload_tdata;
            if (tx_payload_tvalid && tx_payload_tready) begin
                if (nb < 16) txb[nb] = tx_payload_tdata;
                if (tx_payload_tlast) got_last = 1'b1;
                nb++;
            end
            step();
        end
        tx_payload_tready = 1'b0;
        chk("tx_tlast_seen", got_last, 1);
    endtask

    task automatic rx_hdr(input logic [31:0] ip, input logic [15:0] sport);
        int c = 0;
        rx_udp_hdr_valid = 1'b1;
        rx_ip_source_ip = ip;
        rx_udp_source_port = sport;
        rx_udp_dest_port = 16'h6788;
        rx_udp_length = 16'd12;
        while (!rx_udp_hdr_ready && c < 20) begin
            step();
            c++;
        end
        chk("rx_hdr_ready", rx_udp_hdr_ready, 1);
        step();
        rx_udp_hdr_valid = 1'b0;
    endtask

    task automatic rx_pay(input int nb);
        for (int i = 0; i < nb; i++) begin
            int c = 0;
            rx_payload_tvalid = 1'b1;
            rx_payload_tdata = rxb[i];
            rx_payload_tlast = (i == nb - 1);
            while (!rx_payload_tready && c < 20) begin
                step();
                c++;
            end
            chk("rx_tready", rx_payload_tready, 1);
            step();
        end
        rx_payload_tvalid = 1'b0;
        rx_payload_tlast = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_wr = 1'b0; go = 1'b0; cmd_data = '0; dst_ip = '0; rsp_addr = '0;
        tx_udp_hdr_ready = 1'b0; tx_payload_tready = 1'b0;
        rx_udp_hdr_valid = 1'b0; rx_ip_source_ip = '0; rx_udp_source_port = '0;
        rx_udp_dest_port = '0; rx_udp_length = '0; rx_payload_tdata = '0;
        rx_payload_tvalid = 1'b0; rx_payload_tlast = 1'b0; rx_udp_err = 1'b0;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rsp_len", rsp_len, 0);
        chk("rst_hdr_valid", tx_udp_hdr_valid, 0);
        chk("rst_tvalid", tx_payload_tvalid, 0);
        chk("rst_rx_hdr_ready", rx_udp_hdr_ready, 0);
        chk("rst_rx_tready", rx_payload_tready, 0);
        rst = 1'b0;
        step();

        // Basic two-command frame and four-byte response.
        push(16'h0001);
        push(16'h1234);
        start(32'h0a000005);
        chk("t1_busy", busy, 1);
        tx_hdr(32'h0a000005, 16'd16);
        tx_collect(1'b0, n);
        chk("t1_nbytes", n, 8);
        for (int i = 0; i < 8; i++) chk("t1_byte", txb[i], exp_a[i]);
        rx_hdr(32'h0a000005, 16'h6789);
        rxb[0] = 8'hAA; rxb[1] = 8'hBB; rxb[2] = 8'hCC; rxb[3] = 8'hDD;
        rx_pay(4);
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        chk("t1_busy_low", busy, 0);
        chk("t1_rsp_len", rsp_len, 2);
        step();
        chk("t1_done_pulse", done, 0);
        rsp_addr = 4'd0;
        step();
        chk("t1_rsp0", rsp_q, 16'hAABB);
        rsp_addr = 4'd1;
        step();
        chk("t1_rsp1", rsp_q, 16'hCCDD);

        // Random tready stalls, then a foreign frame before the real response.
        push(16'hA1B2);
        push(16'hC3D4);
        push(16'hE5F6);
        start(32'h0a000005);
        chk("t2_rsp_len_clr", rsp_len, 0);
        tx_hdr(32'h0a000005, 16'd18);
        tx_collect(1'b1, n);
        chk("t2_nbytes", n, 10);
        for (int i = 0; i < 10; i++) chk("t2_byte", txb[i], exp_b[i]);
        rx_hdr(32'h0a000009, 16'h6789);
        rxb[0] = 8'h11; rxb[1] = 8'h22;
        rx_pay(2);
        chk("t2_foreign_busy", busy, 1);
        chk("t2_foreign_done", done, 0);
        chk("t2_foreign_len", rsp_len, 0);
        rx_hdr(32'h0a000005, 16'h6789);
        rxb[0] = 8'hAA; rxb[1] = 8'hBB;
        rx_pay(2);
        chk("t2_done", done, 1);
        chk("t2_rsp_len", rsp_len, 1);

        // Odd-length response is an error; the complete pair is still stored.
        push(16'h0102);
        start(32'h0a000005);
        tx_hdr(32'h0a000005, 16'd14);
        tx_collect(1'b0, n);
        chk("t3_nbytes", n, 6);
        rx_hdr(32'h0a000005, 16'h6789);
        rxb[0] = 8'h01; rxb[1] = 8'h02; rxb[2] = 8'h03;
        rx_pay(3);
        chk("t3_err", err, 1);
        chk("t3_done", done, 0);
        chk("t3_rsp_len", rsp_len, 1);
        rsp_addr = 4'd0;
        step();
        chk("t3_rsp0", rsp_q, 16'h0102);

        // No response: err exactly 100 cycles after the tlast handshake.
        push(16'h5555);
        start(32'h0a000005);
        chk("t4_rsp_len_clr", rsp_len, 0);
        tx_hdr(32'h0a000005, 16'd14);
        tx_collect(1'b0, n);
        cnt = 0;
        while (!err && cnt < 200) begin
            step();
            cnt++;
        end
        chk("t4_timeout_cycles", cnt, 100);
        chk("t4_busy", busy, 0);
        step();
        chk("t4_err_pulse", err, 0);

        // Empty buffer: err, no header.
        start(32'h0a000005);
        chk("t5_err", err, 1);
        chk("t5_busy", busy, 0);
        chk("t5_hdr", tx_udp_hdr_valid, 0);
        step();
        step();
        chk("t5_hdr_later", tx_udp_hdr_valid, 0);
        chk("t5_err_pulse", err, 0);

        // Overflow: 15 pushes into a 14-entry limit, go reports err and clears the buffer.
        for (int i = 0; i < 15; i++) push(16'(i));
        start(32'h0a000005);
        chk("t6_ovf_err", err, 1);
        chk("t6_ovf_hdr", tx_udp_hdr_valid, 0);
        push(16'h7777);
        start(32'h0a000006);
        tx_hdr(32'h0a000006, 16'd14);

        // Reset in the middle of the payload.
        tx_payload_tready = 1'b1;
        step();
        step();
        rst = 1'b1;
        tx_payload_tready = 1'b0;
        step();
        chk("t7_tvalid", tx_payload_tvalid, 0);
        chk("t7_tlast", tx_payload_tlast, 0);
        chk("t7_hdr_valid", tx_udp_hdr_valid, 0);
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_err", err, 0);
        chk("t7_rx_hdr_ready", rx_udp_hdr_ready, 0);
        rst = 1'b0;
        step();
        start(32'h0a000005);
        chk("t7_cnt_cleared", err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
